// File: rtl/fft_pkg.sv
// Shared constants, types and FSM encoding for the 16-point FFT sequencing controller.
package fft_pkg;

  localparam int SAMPLE_W = 17;
  localparam int N_PTS    = 16;
  localparam int N_OPS    = 8;
  localparam int BF_W     = 136;
  localparam int DATA_W   = 2 * SAMPLE_W;
  localparam int N_SLOT   = 4;
  localparam int IDX_W    = 4;
  localparam int OP_W     = 3;

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [OP_W-1:0]   op_t;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } state_t;

  // Base-4 digit reversal of a 2-digit index: swap the two radix-4 digits.
  function automatic idx_t digit_rev(input idx_t c);
    return {c[1:0], c[3:2]};
  endfunction

endpackage

// File: rtl/fft_ctrl_if.sv
// Stream-in, stream-out and butterfly-port bundle between the FFT controller and its environment.
interface fft_ctrl_if;
  import fft_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [DATA_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DATA_W-1:0] out_data;
  logic            out_last;
  logic [BF_W-1:0] bf_calc_in;
  logic [OP_W-1:0] bf_rotation;
  logic [BF_W-1:0] bf_calc_out;

  // Environment side: sample source, result sink and butterfly unit.
  modport master (
    output in_valid, in_data, out_ready, bf_calc_out,
    input  in_ready, out_valid, out_data, out_last, bf_calc_in, bf_rotation
  );

  // Controller side.
  modport slave (
    input  in_valid, in_data, out_ready, bf_calc_out,
    output in_ready, out_valid, out_data, out_last, bf_calc_in, bf_rotation
  );

endinterface

// File: rtl/fft_addr_gen.sv
// Combinational index generation: butterfly operand indices per op, and digit-reversed read index.
module fft_addr_gen
  import fft_pkg::*;
(
  input  op_t                 i_op,
  input  idx_t                i_out_cnt,
  output idx_t [N_SLOT-1:0]   o_bf_idx,
  output idx_t                o_rd_idx
);

  // Stage 1 (op 0..3) strides by 4 over one low digit; stage 2 (op 4..7) takes 4 consecutive.
  always_comb begin
    o_bf_idx = '0;
    for (int j = 0; j < N_SLOT; j++) begin
      if (!i_op[2]) begin
        o_bf_idx[j] = {2'(j), i_op[1:0]};
      end else begin
        o_bf_idx[j] = {i_op[1:0], 2'(j)};
      end
    end
  end

  assign o_rd_idx = digit_rev(i_out_cnt);

endmodule

// File: rtl/fft_ctrl.sv
// 16-point radix-4 FFT sequencing controller: loads a frame, drives 8 in-place butterfly ops, unloads digit-reversed.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_LOAD    | accept 16 input samples into the buffer, in_ready high
// ST_COMPUTE | present 4 operands per op, capture results after BF_LAT
// ST_UNLOAD  | stream 16 results in digit-reversed order, last on 16th
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int BF_LAT = 1
)
(
  input  logic       clk,
  input  logic       reset,
  fft_ctrl_if.slave  bus,
  output logic       busy
);

  localparam logic [OP_W-1:0]  LP_LAT   = OP_W'(BF_LAT);
  localparam idx_t             LAST_IDX = IDX_W'(N_PTS - 1);
  localparam op_t              LAST_OP  = OP_W'(N_OPS - 1);

  state_t            r_state;
  idx_t              r_ld_cnt;
  op_t               r_op;
  logic [OP_W-1:0]   r_wait;
  idx_t              r_out_cnt;
  sample_t           r_buf [N_PTS];

  state_t            w_next_state;
  idx_t [N_SLOT-1:0] w_bf_idx;
  idx_t              w_rd_idx;
  logic              w_load_acc;
  logic              w_capture;
  logic              w_out_acc;
  logic [BF_W-1:0]   w_bf_pack;

  fft_addr_gen u_addr_gen (
    .i_op      (r_op),
    .i_out_cnt (r_out_cnt),
    .o_bf_idx  (w_bf_idx),
    .o_rd_idx  (w_rd_idx)
  );

  assign w_load_acc = (r_state == ST_LOAD) && bus.in_valid;
  assign w_capture  = (r_state == ST_COMPUTE) && (r_wait == LP_LAT);
  assign w_out_acc  = (r_state == ST_UNLOAD) && bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_LOAD:    if (w_load_acc && (r_ld_cnt == LAST_IDX)) w_next_state = ST_COMPUTE;
      ST_COMPUTE: if (w_capture && (r_op == LAST_OP))       w_next_state = ST_UNLOAD;
      ST_UNLOAD:  if (w_out_acc && (r_out_cnt == LAST_IDX)) w_next_state = ST_LOAD;
      default:    w_next_state = ST_LOAD;
    endcase
  end

  // Operands come straight from the buffer; they cannot move until this op's capture cycle.
  always_comb begin
    w_bf_pack = '0;
    if (r_state == ST_COMPUTE) begin
      for (int j = 0; j < N_SLOT; j++) begin
        w_bf_pack[j*DATA_W +: DATA_W] = r_buf[w_bf_idx[j]];
      end
    end
  end

  assign bus.in_ready    = (r_state == ST_LOAD);
  assign bus.out_valid   = (r_state == ST_UNLOAD);
  assign bus.out_data    = (r_state == ST_UNLOAD) ? r_buf[w_rd_idx] : '0;
  assign bus.out_last    = (r_state == ST_UNLOAD) && (r_out_cnt == LAST_IDX);
  assign bus.bf_calc_in  = w_bf_pack;
  assign bus.bf_rotation = (r_state == ST_COMPUTE) ? r_op : '0;
  assign busy            = (r_state == ST_COMPUTE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_cnt  <= '0;
      r_op      <= '0;
      r_wait    <= '0;
      r_out_cnt <= '0;
      for (int i = 0; i < N_PTS; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_load_acc) begin
            r_buf[r_ld_cnt] <= bus.in_data;
            r_ld_cnt        <= r_ld_cnt + 1'b1;
            if (r_ld_cnt == LAST_IDX) begin
              r_op   <= '0;
              r_wait <= '0;
            end
          end
        end
        ST_COMPUTE: begin
          if (w_capture) begin
            for (int j = 0; j < N_SLOT; j++) begin
              r_buf[w_bf_idx[j]] <= bus.bf_calc_out[j*DATA_W +: DATA_W];
            end
            r_op   <= r_op + 1'b1;
            r_wait <= '0;
            if (r_op == LAST_OP) begin
              r_out_cnt <= '0;
            end
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        ST_UNLOAD: begin
          if (w_out_acc) begin
            r_out_cnt <= r_out_cnt + 1'b1;
            if (r_out_cnt == LAST_IDX) begin
              r_ld_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_ctrl.sv
// Scoreboard bench for fft_ctrl: BF_LAT=1 and BF_LAT=3 instances with a pass-through / +1 butterfly stub.
module tb_fft_ctrl;

  typedef struct packed {
    logic [33:0] d;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n1 = 1'b0;
  logic rst_n3 = 1'b0;
  logic busy1, busy3;
  logic sel = 1'b0;
  logic stub_add = 1'b0;

  logic        d_in_valid = 1'b0;
  logic [33:0] d_in_data  = '0;
  logic        d_out_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_beats = 0;

  exp_t        exp_q[$];
  logic [33:0] frm [16];

  fft_ctrl_if ifc1();
  fft_ctrl_if ifc3();

  fft_ctrl #(.BF_LAT(1)) u_dut1 (.clk(clk), .reset(rst_n1), .bus(ifc1.slave), .busy(busy1));
  fft_ctrl #(.BF_LAT(3)) u_dut3 (.clk(clk), .reset(rst_n3), .bus(ifc3.slave), .busy(busy3));

  always #5 clk = ~clk;

  function automatic logic [135:0] stub_f(input logic [135:0] x, input logic add);
    logic [135:0] y;
    y = x;
    for (int j = 0; j < 4; j++) y[j*34+33 -: 17] = x[j*34+33 -: 17] + 17'(add);
    return y;
  endfunction

  assign ifc1.bf_calc_out = stub_f(ifc1.bf_calc_in, stub_add);
  assign ifc3.bf_calc_out = stub_f(ifc3.bf_calc_in, stub_add);
  assign ifc1.in_valid  = !sel && d_in_valid;
  assign ifc3.in_valid  =  sel && d_in_valid;
  assign ifc1.in_data   = d_in_data;
  assign ifc3.in_data   = d_in_data;
  assign ifc1.out_ready = !sel && d_out_ready;
  assign ifc3.out_ready =  sel && d_out_ready;

  logic         s_busy, s_in_ready, s_out_valid, s_out_last;
  logic [2:0]   s_rot;
  logic [33:0]  s_out_data;
  logic [135:0] s_calc_in;
  assign s_busy      = sel ? busy3            : busy1;
  assign s_in_ready  = sel ? ifc3.in_ready    : ifc1.in_ready;
  assign s_out_valid = sel ? ifc3.out_valid   : ifc1.out_valid;
  assign s_out_last  = sel ? ifc3.out_last    : ifc1.out_last;
  assign s_out_data  = sel ? ifc3.out_data    : ifc1.out_data;
  assign s_rot       = sel ? ifc3.bf_rotation : ifc1.bf_rotation;
  assign s_calc_in   = sel ? ifc3.bf_calc_in  : ifc1.bf_calc_in;

  task automatic check(input string nm, input logic [135:0] act, input logic [135:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat, checks hold while stalled.
  logic        have_ref = 1'b0;
  logic [33:0] ref_data;
  logic        ref_last;
  always @(negedge clk) begin
    exp_t e;
    if (s_out_valid && d_out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got out_data %h with nothing expected", s_out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", s_out_data, e.d);
        check("out_last", s_out_last, e.l);
      end
      n_beats++;
      have_ref = 1'b0;
    end else if (s_out_valid) begin
      if (have_ref) begin
        check("hold_data", s_out_data, ref_data);
        check("hold_last", s_out_last, ref_last);
      end else begin
        ref_data = s_out_data;
        ref_last = s_out_last;
        have_ref = 1'b1;
      end
    end else begin
      check("idle_last", s_out_last, 0);
    end
    if (!s_busy) begin
      check("rot_idle", s_rot, 0);
      check("calc_in_idle", s_calc_in, 0);
    end
  end

  task automatic make_frame(input int base, input int im_step);
    for (int k = 0; k < 16; k++) frm[k] = {17'(base + k), 17'(k * im_step)};
  endtask

  task automatic push_exp(input bit add);
    exp_t e;
    logic [16:0] re;
    for (int m = 0; m < 16; m++) begin
      int src;
      src = (m % 4) * 4 + m / 4;
      re = frm[src][33:17] + (add ? 17'd2 : 17'd0);
      e.d = {re, frm[src][16:0]};
      e.l = (m == 15);
      exp_q.push_back(e);
    end
  endtask

  task automatic load_frame(input bit gap);
    for (int k = 0; k < 16; k++) begin
      d_in_data  = frm[k];
      d_in_valid = 1'b1;
      check("in_ready_load", s_in_ready, 1);
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      if (gap && k[0] && k != 15) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Called at the start of the first COMPUTE cycle.
  task automatic watch(input int lat, input bit add, input int abort_op, input bit junk);
    int cyc;
    logic [16:0] re;
    cyc = 0;
    while (cyc < 200) begin
      if (junk) begin
        d_in_valid = 1'b1;
        d_in_data  = 34'($urandom);
      end
      @(negedge clk);
      if (!s_busy) break;
      check("rotation", s_rot, cyc / (lat + 1));
      if (junk) check("in_ready_busy", s_in_ready, 0);
      if (cyc == 0 || cyc == lat) begin
        for (int j = 0; j < 4; j++) check("op0_slot", s_calc_in[j*34 +: 34], frm[4*j]);
      end
      if (cyc == 4 * (lat + 1)) begin
        for (int j = 0; j < 4; j++) begin
          re = frm[j][33:17] + 17'(add);
          check("op4_slot", s_calc_in[j*34 +: 34], {re, frm[j][16:0]});
        end
      end
      if (abort_op >= 0 && cyc == abort_op * (lat + 1)) begin
        if (sel) rst_n3 = 1'b0; else rst_n1 = 1'b0;
        @(negedge clk);
        rst_n1 = 1'b1;
        rst_n3 = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        check("abort_in_ready", s_in_ready, 1);
        check("abort_busy", s_busy, 0);
        check("abort_out_valid", s_out_valid, 0);
        return;
      end
      cyc++;
      @(posedge clk); #1;
    end
    d_in_valid = 1'b0;
    check("compute_cycles", cyc, 8 * (lat + 1));
  endtask

  task automatic unload(input bit stall, input bit junk);
    int start, b, stall_cnt;
    start = n_beats;
    b = 0;
    stall_cnt = 0;
    while ((n_beats - start) < 16 && b < 400) begin
      @(posedge clk); #1;
      b++;
      if (stall && (n_beats - start) == 3 && stall_cnt < 5) begin
        d_out_ready = 1'b0;
        stall_cnt++;
      end else begin
        d_out_ready = 1'b1;
      end
      d_in_valid = junk && ((n_beats - start) < 12);
      d_in_data  = 34'($urandom);
      if (junk && d_in_valid) check("in_ready_unload", s_in_ready, 0);
    end
    d_out_ready = 1'b0;
    d_in_valid  = 1'b0;
    check("unload_beats", n_beats - start, 16);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic run_frame(input int lat, input int base, input int im_step, input bit add,
                           input bit gap, input bit stall, input bit junk);
    stub_add = add;
    make_frame(base, im_step);
    push_exp(add);
    load_frame(gap);
    watch(lat, add, -1, junk);
    unload(stall, junk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n1 = 1'b1;
    rst_n3 = 1'b1;
    @(posedge clk); #1;
    check("rst1_in_ready", ifc1.in_ready, 1);
    check("rst1_out_valid", ifc1.out_valid, 0);
    check("rst1_out_last", ifc1.out_last, 0);
    check("rst1_busy", busy1, 0);
    check("rst1_rot", ifc1.bf_rotation, 0);
    check("rst1_calc_in", ifc1.bf_calc_in, 0);
    check("rst3_in_ready", ifc3.in_ready, 1);
    check("rst3_busy", busy3, 0);
    check("rst3_out_valid", ifc3.out_valid, 0);

    run_frame(1, 0,        0,       1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(1, 'h100,    3,       1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(1, 'h1F000,  'h1111,  1'b0, 1'b0, 1'b1, 1'b1);

    stub_add = 1'b0;
    make_frame('h55, 1);
    push_exp(1'b0);
    load_frame(1'b0);
    watch(1, 1'b0, 5, 1'b0);
    run_frame(1, 'h200,    7,       1'b1, 1'b0, 1'b0, 1'b0);

    sel = 1'b1;
    @(posedge clk); #1;
    run_frame(3, 0,        0,       1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(3, 'h300,    5,       1'b1, 1'b1, 1'b1, 1'b1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 SHALL have parameter BF_LAT, default 1, meaning butterfly latency in cycles from bf_calc_in/bf_rotation to valid bf_calc_out (range 0..7).
REQ-002 SHALL have port: clk  input  1  the single clock; all flops rising-edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  input sample valid.
REQ-005 SHALL have port: in_ready  output  1  controller accepts an input sample.
REQ-006 SHALL have port: in_data  input  34  sample {Re[16:0], Im[16:0]}, signed.
REQ-007 SHALL have port: out_valid  output  1  output sample valid.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts an output sample.
REQ-009 SHALL have port: out_data  output  34  result {Re, Im}.
REQ-010 SHALL have port: out_last  output  1  high with the 16th output sample.
REQ-011 SHALL have port: busy  output  1  high in COMPUTE.
REQ-012 SHALL have port: bf_calc_in  output  136  four samples to butterfly; slot j at [34j+33:34j], j=0 LSB.
REQ-013 SHALL have port: bf_rotation  output  3  butterfly op index 0..7.
REQ-014 SHALL have port: bf_calc_out  input  136  butterfly results, same packing.

Function
REQ-015 SHALL hold a 16 x 34-bit sample buffer and a three-state FSM: LOAD, COMPUTE, UNLOAD.
REQ-016 LOAD: in_ready=1; each in_valid&in_ready cycle writes buf[ld_cnt], ld_cnt increments; on the 16th accept, go to COMPUTE next cycle with op=0, wait=0.
REQ-017 COMPUTE: op 0..3 (stage 1, b=op) uses indices {b, b+4, b+8, b+12} in slots 0..3; op 4..7 (stage 2, k=op-4) uses {4k, 4k+1, 4k+2, 4k+3}.
REQ-018 COMPUTE: bf_rotation=op; bf_calc_in = selected samples, held stable for the whole op.
REQ-019 Each op SHALL last BF_LAT+1 cycles; in the cycle wait==BF_LAT, bf_calc_out slot j is written in place to the index of slot j, op increments, wait clears.
REQ-020 After op 7 writes back, the FSM SHALL go to UNLOAD with out_cnt=0; total COMPUTE = 8*(BF_LAT+1) cycles (16 for default).
REQ-021 UNLOAD: out_valid=1, out_data = buf[(out_cnt mod 4)*4 + out_cnt/4] (base-4 digit reversal); out_cnt advances only on out_valid&out_ready.
REQ-022 out_last=1 iff UNLOAD and out_cnt==15; the handshake on that beat SHALL return the FSM to LOAD with ld_cnt=0.
REQ-023 While out_ready=0, out_data/out_last SHALL hold unchanged.
REQ-024 in_ready SHALL be 0 outside LOAD; in_valid outside LOAD SHALL be ignored, with no buffer write.
REQ-025 bf_calc_in and bf_rotation SHALL be 0 outside COMPUTE; bf_calc_out SHALL be ignored outside the capture cycle.
REQ-026 The controller SHALL do no arithmetic; the data path is pure move, no width change.

Reset
REQ-027 On reset low: FSM=LOAD; ld_cnt, op, wait and out_cnt = 0; buffer cleared; in_ready=1 after release; out_valid, out_last, busy, bf_rotation and bf_calc_in = 0.
REQ-028 Reset asserted mid-frame (any state) SHALL abort the frame with no partial output; the next frame restarts at sample 0.

Structure
REQ-029 Shared package fft_pkg SHALL hold SAMPLE_W=17, N_PTS=16, N_OPS=8, BF_W=136 and the FSM state encoding, reused by butterfly and top level.
REQ-030 Index generation (op to four indices, and out_cnt to digit-reversed index) SHALL be a separate combinational sub-module fft_addr_gen.

Verification
REQ-031 Identity stub (calc_out=calc_in), load Re=k, Im=0 for k=0..15 -> outputs Re = 0,4,8,12,1,5,9,13,2,...,15; out_last only on the 16th beat.
REQ-032 Stub adding +1 to every Re -> every output Re = source index + 2, proving each sample is processed exactly twice.
REQ-033 Monitor COMPUTE with BF_LAT=1 -> bf_rotation = 0,0,1,1,...,7,7 over 16 cycles; op0 bf_calc_in slots hold samples 0,4,8,12; op4 slots hold 0,1,2,3.
REQ-034 Hold out_ready=0 for 5 cycles at out_cnt=3 -> out_data is stable; no sample lost or duplicated; in_valid pulses during COMPUTE/UNLOAD leave in_ready=0 and the results unchanged.
REQ-035 Assert reset for 1 cycle at COMPUTE op 5, then load a fresh frame -> correct fresh results, no stale samples; BF_LAT=3 run -> COMPUTE lasts 32 cycles with the same results.
